// File: rtl/event_buffer_controller.sv
// Event buffer controller: timestamps trigger edges, waits for the TOT settle delay,
// then stores {timestamp, TOT_SHORT, TOT_LONG} records in a FIFO drained via RD_REQ.
module event_buffer_controller #(
  parameter int DEPTH = 256,
  parameter int TS_W  = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TRIGGER_ACTIVE,
  input  logic [15:0]         TOT_SHORT,
  input  logic [15:0]         TOT_LONG,
  input  logic [15:0]         mconfig,
  input  logic                RD_REQ,
  output logic                RD_VALID,
  output logic [TS_W+31:0]    RD_DATA,
  output logic [$clog2(DEPTH):0] FIFO_COUNT,
  output logic                FIFO_FULL,
  output logic                FIFO_EMPTY,
  output logic [31:0]         NTRIGGERS,
  output logic [15:0]         OVERFLOWS,
  output logic [2:0]          STATE,
  output logic                ACQ_STOPPED
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    HOLD    = 3'd4,
    STOPPED = 3'd5
  } state_t;

  state_t state, state_next;

  logic       enable, clear, stop_on_full;
  logic [7:0] settle;
  logic       unused_cfg;

  logic             trig_prev, trig_edge;
  logic [TS_W-1:0]  ts_count, ts_latch;
  logic [7:0]       settle_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             full, empty;
  logic             rd_accept, wr_attempt, wr_accept;
  logic [TS_W+31:0] mem [DEPTH];
  logic [TS_W+31:0] rd_data;
  logic             rd_valid;
  logic [31:0]      ntriggers;
  logic [15:0]      overflows;

  assign enable       = mconfig[0];
  assign clear        = mconfig[1];
  assign stop_on_full = mconfig[2];
  assign settle       = mconfig[15:8];
  assign unused_cfg   = ^mconfig[7:3];

  assign trig_edge  = TRIGGER_ACTIVE & ~trig_prev;
  assign rd_accept  = RD_REQ & ~empty;
  assign wr_attempt = (state == WRITE) & enable;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_accept  = wr_attempt & (~full | rd_accept);
  assign count_next = count + {AW'(0), wr_accept} - {AW'(0), rd_accept};

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = enable ? ARMED : IDLE;
    end else if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARMED;
        ARMED:   if (trig_edge) state_next = (settle == 8'd0) ? WRITE : CAPTURE;
        CAPTURE: if (settle_cnt <= 8'd1) state_next = WRITE;
        WRITE:   state_next = (stop_on_full && count_next == FULL_COUNT) ? STOPPED : HOLD;
        HOLD:    if (!TRIGGER_ACTIVE) state_next = ARMED;
        STOPPED: if (empty && !stop_on_full) state_next = ARMED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      trig_prev  <= 1'b0;
      ts_count   <= '0;
      ts_latch   <= '0;
      settle_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      ntriggers  <= '0;
      overflows  <= '0;
    end else begin
      trig_prev <= TRIGGER_ACTIVE;
      rd_valid  <= 1'b0;
      if (clear) begin
        ts_count   <= '0;
        settle_cnt <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        full       <= 1'b0;
        empty      <= 1'b1;
        ntriggers  <= '0;
        overflows  <= '0;
      end else begin
        ts_count <= ts_count + TS_W'(1);
        if (state == ARMED && trig_edge) begin
          ts_latch   <= ts_count;
          settle_cnt <= settle;
        end else if (state == CAPTURE && settle_cnt != 8'd0) begin
          settle_cnt <= settle_cnt - 8'd1;
        end
        if (rd_accept) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + AW'(1);
        end
        if (wr_accept) begin
          wr_ptr    <= wr_ptr + AW'(1);
          ntriggers <= ntriggers + 32'd1;
        end else if (wr_attempt && overflows != 16'hFFFF) begin
          overflows <= overflows + 16'd1;
        end
        count <= count_next;
        full  <= (count_next == FULL_COUNT);
        empty <= (count_next == '0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && !clear && wr_accept) mem[wr_ptr] <= {ts_latch, TOT_SHORT, TOT_LONG};
  end

  assign RD_VALID    = rd_valid;
  assign RD_DATA     = rd_data;
  assign FIFO_COUNT  = count;
  assign FIFO_FULL   = full;
  assign FIFO_EMPTY  = empty;
  assign NTRIGGERS   = ntriggers;
  assign OVERFLOWS   = overflows;
  assign STATE       = state;
  assign ACQ_STOPPED = (state == STOPPED);

endmodule

// File: tb/tb_event_buffer_controller.sv
// Randomized bench for event_buffer_controller against a transaction-level queue model
// of the event FIFO and its counters.
module tb_event_buffer_controller;
  localparam int DEPTH = 256;
  localparam int TS_W  = 32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TRIGGER_ACTIVE;
  logic [15:0] TOT_SHORT, TOT_LONG;
  logic [15:0] mconfig;
  logic        RD_REQ;
  logic        RD_VALID;
  logic [63:0] RD_DATA;
  logic [8:0]  FIFO_COUNT;
  logic        FIFO_FULL, FIFO_EMPTY;
  logic [31:0] NTRIGGERS;
  logic [15:0] OVERFLOWS;
  logic [2:0]  STATE;
  logic        ACQ_STOPPED;

  event_buffer_controller #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .CLK(CLK), .RESET(RESET), .TRIGGER_ACTIVE(TRIGGER_ACTIVE),
    .TOT_SHORT(TOT_SHORT), .TOT_LONG(TOT_LONG), .mconfig(mconfig),
    .RD_REQ(RD_REQ), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .FIFO_COUNT(FIFO_COUNT), .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
    .NTRIGGERS(NTRIGGERS), .OVERFLOWS(OVERFLOWS), .STATE(STATE),
    .ACQ_STOPPED(ACQ_STOPPED)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_q[$];
  int          m_ntrig = 0;
  int          m_ovf   = 0;
  logic [63:0] last_data = '0;
  logic [31:0] tb_ts = '0;

  // Expected timestamp: cycles since the last reset or clear.
  always @(posedge CLK) begin
    if (!RESET || mconfig[1]) tb_ts <= '0;
    else                      tb_ts <= tb_ts + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_count"}, 64'(FIFO_COUNT), 64'(model_q.size()));
    checkOutput({tag, "_full"},  64'(FIFO_FULL),  64'(model_q.size() == DEPTH));
    checkOutput({tag, "_empty"}, 64'(FIFO_EMPTY), 64'(model_q.size() == 0));
    checkOutput({tag, "_ntrig"}, 64'(NTRIGGERS),  64'(m_ntrig));
    checkOutput({tag, "_ovf"},   64'(OVERFLOWS),  64'(m_ovf));
  endtask

  // One trigger from ARMED with the trigger low: edge, settle, write, hold, release.
  task automatic applyStimulus(input logic [7:0] settle, input logic [15:0] tot_s,
                               input logic [15:0] tot_l, input bit pop_in_write,
                               input bit glitch, input int hold_extra);
    logic [31:0] edge_ts;
    logic [63:0] exp_pop;
    bit          popped;
    int          exp_state;
    mconfig[15:8]  = settle;
    TRIGGER_ACTIVE = 1'b1;
    TOT_SHORT      = ~tot_s;
    TOT_LONG       = ~tot_l;
    edge_ts        = tb_ts;
    exp_pop        = '0;
    for (int i = 1; i <= int'(settle); i++) begin
      @(negedge CLK);
      if (glitch && i == 1) TRIGGER_ACTIVE = 1'b0;
      if (glitch && i == 2) TRIGGER_ACTIVE = 1'b1;
    end
    @(negedge CLK);
    checkOutput("write_state", 64'(STATE), 64'(3));
    TOT_SHORT = tot_s;
    TOT_LONG  = tot_l;
    RD_REQ    = pop_in_write;
    popped = pop_in_write && model_q.size() > 0;
    if (popped) exp_pop = model_q.pop_front();
    if (model_q.size() < DEPTH) begin
      model_q.push_back({edge_ts, tot_s, tot_l});
      m_ntrig++;
    end else if (m_ovf != 16'hFFFF) begin
      m_ovf++;
    end
    exp_state = (mconfig[2] && model_q.size() == DEPTH) ? 5 : 4;
    @(negedge CLK);
    RD_REQ = 1'b0;
    checkOutput("wr_rd_valid", 64'(RD_VALID), 64'(popped));
    if (popped) begin
      checkOutput("wr_rd_data", RD_DATA, exp_pop);
      last_data = exp_pop;
    end
    checkCounters("trig");
    checkOutput("post_write_state", 64'(STATE), 64'(exp_state));
    checkOutput("acq_stopped", 64'(ACQ_STOPPED), 64'(exp_state == 5));
    repeat (hold_extra) @(negedge CLK);
    TRIGGER_ACTIVE = 1'b0;
    @(negedge CLK);
    checkOutput("release_state", 64'(STATE), 64'((exp_state == 5) ? 5 : 1));
  endtask

  task automatic popCheck();
    logic [63:0] exp;
    bit          has;
    has = model_q.size() > 0;
    exp = has ? model_q.pop_front() : last_data;
    RD_REQ = 1'b1;
    @(negedge CLK);
    RD_REQ = 1'b0;
    checkOutput("rd_valid", 64'(RD_VALID), 64'(has));
    checkOutput("rd_data", RD_DATA, exp);
    last_data = exp;
    checkOutput("rd_count", 64'(FIFO_COUNT), 64'(model_q.size()));
    checkOutput("rd_empty", 64'(FIFO_EMPTY), 64'(model_q.size() == 0));
    @(negedge CLK);
    checkOutput("rd_pulse", 64'(RD_VALID), 64'(0));
    checkOutput("rd_hold", RD_DATA, exp);
  endtask

  // Clear with a simultaneous read request, which must be ignored.
  task automatic clearPulse();
    mconfig[1] = 1'b1;
    RD_REQ     = 1'b1;
    @(negedge CLK);
    mconfig[1] = 1'b0;
    RD_REQ     = 1'b0;
    model_q.delete();
    m_ntrig = 0;
    m_ovf   = 0;
    checkCounters("clear");
    checkOutput("clear_rd_valid", 64'(RD_VALID), 64'(0));
    checkOutput("clear_state", 64'(STATE), 64'(mconfig[0] ? 1 : 0));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"},    64'(STATE),       64'(0));
    checkOutput({tag, "_rd_valid"}, 64'(RD_VALID),    64'(0));
    checkOutput({tag, "_rd_data"},  RD_DATA,          64'(0));
    checkOutput({tag, "_count"},    64'(FIFO_COUNT),  64'(0));
    checkOutput({tag, "_empty"},    64'(FIFO_EMPTY),  64'(1));
    checkOutput({tag, "_full"},     64'(FIFO_FULL),   64'(0));
    checkOutput({tag, "_ntrig"},    64'(NTRIGGERS),   64'(0));
    checkOutput({tag, "_ovf"},      64'(OVERFLOWS),   64'(0));
    checkOutput({tag, "_acq"},      64'(ACQ_STOPPED), 64'(0));
  endtask

  task automatic modelReset();
    model_q.delete();
    m_ntrig   = 0;
    m_ovf     = 0;
    last_data = '0;
  endtask

  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] s;
    RESET = 1'b0; TRIGGER_ACTIVE = 1'b0; TOT_SHORT = '0; TOT_LONG = '0;
    mconfig = 16'h0000; RD_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    checkResetValues("reset");
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("idle_disabled", 64'(STATE), 64'(0));

    // Known-timestamp capture: edge at ts 100, settle 3.
    mconfig = {8'd3, 5'd0, 1'b0, 1'b0, 1'b1};
    @(negedge CLK);
    checkOutput("armed", 64'(STATE), 64'(1));
    for (int k = 0; k < 200 && tb_ts != 32'd100; k++) @(negedge CLK);
    checkOutput("reach_ts100", 64'(tb_ts), 64'(100));
    applyStimulus(8'd3, 16'h0012, 16'h0345, 1'b0, 1'b0, 2);
    popCheck();
    checkOutput("rec_ts100", RD_DATA, 64'h00000064_0012_0345);

    // Long trigger with a second edge during capture: one record only.
    applyStimulus(8'd4, 16'hBEEF, 16'h1234, 1'b0, 1'b1, 50);
    checkOutput("single_record_ntrig", 64'(NTRIGGERS), 64'(2));
    clearPulse();

    // Fill past full without stop-on-full.
    for (int n = 0; n < 260; n++)
      applyStimulus(8'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 1'b0, 1'b0,
                    $urandom_range(0, 3));
    checkOutput("fill_count", 64'(FIFO_COUNT), 64'(256));
    checkOutput("fill_full", 64'(FIFO_FULL), 64'(1));
    checkOutput("fill_ovf", 64'(OVERFLOWS), 64'(4));
    checkOutput("fill_ntrig", 64'(NTRIGGERS), 64'(256));

    // Write coincident with a pop while full.
    applyStimulus(8'd2, 16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 0);
    checkOutput("coinc_count", 64'(FIFO_COUNT), 64'(256));
    checkOutput("coinc_ovf", 64'(OVERFLOWS), 64'(4));

    for (int n = 0; n < DEPTH; n++) popCheck();
    checkOutput("drain_empty", 64'(FIFO_EMPTY), 64'(1));
    popCheck();

    // Stop-on-full.
    clearPulse();
    mconfig[2] = 1'b1;
    for (int n = 0; n < DEPTH; n++)
      applyStimulus(8'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 0);
    checkOutput("stop_state", 64'(STATE), 64'(5));
    checkOutput("stop_acq", 64'(ACQ_STOPPED), 64'(1));
    TRIGGER_ACTIVE = 1'b1;
    repeat (3) @(negedge CLK);
    TRIGGER_ACTIVE = 1'b0;
    @(negedge CLK);
    checkCounters("stopped_trig");
    checkOutput("stopped_stays", 64'(STATE), 64'(5));
    popCheck();
    checkOutput("stopped_after_pop", 64'(STATE), 64'(5));
    clearPulse();
    mconfig[2] = 1'b0;

    // Random mix of triggers and pops.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        popCheck();
      end else begin
        s = 8'($urandom_range(0, 5));
        applyStimulus(s, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      (s >= 8'd2) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
      end
    end

    // ENABLE dropped during capture.
    mconfig[15:8]  = 8'd5;
    TRIGGER_ACTIVE = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("capture_state", 64'(STATE), 64'(2));
    mconfig[0] = 1'b0;
    @(negedge CLK);
    checkOutput("disable_idle", 64'(STATE), 64'(0));
    checkCounters("disable");
    TRIGGER_ACTIVE = 1'b0;
    mconfig[0]     = 1'b1;
    @(negedge CLK);
    checkOutput("reenable", 64'(STATE), 64'(1));
    repeat (3) @(negedge CLK);
    checkCounters("disable_late");

    // Reset asserted during capture.
    TRIGGER_ACTIVE = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checkResetValues("midreset");
    RESET = 1'b1;
    TRIGGER_ACTIVE = 1'b0;
    modelReset();
    @(negedge CLK);
    checkOutput("post_reset_state", 64'(STATE), 64'(1));
    checkCounters("post_reset");
    applyStimulus(8'd1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1);
    popCheck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_buffer_controller.md
EVENT_BUFFER_CONTROLLER -- requirements
Module: event_buffer_controller

Interface
REQ-001 Parameter DEPTH, default 256, sets the event FIFO depth in records and SHALL be a power of two; AW = log2(DEPTH).
REQ-002 Parameter TS_W, default 32, sets the timestamp width in bits.
REQ-003 Port CLK, input, 1 bit: the fast acquisition clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port RESET, input, 1 bit: synchronous, active-low reset.
REQ-005 Port TRIGGER_ACTIVE, input, 1 bit: trigger level from the trigger handler.
REQ-006 Ports TOT_SHORT and TOT_LONG, input, 16 bits each: short-window and long-window TOT values.
REQ-007 Port mconfig, input, 16 bits:
- bit0: ENABLE.
- bit1: CLEAR, level-sensitive.
- bit2: STOP_ON_FULL.
- bits[15:8]: SETTLE, TOT settle delay in cycles.
REQ-008 Port RD_REQ, input, 1 bit: pop request, one cycle per record.
REQ-009 Port RD_VALID, output, 1 bit: RD_DATA is valid this cycle.
REQ-010 Port RD_DATA, output, TS_W+32 bits: record {timestamp, TOT_SHORT, TOT_LONG}, with timestamp in the MSBs.
REQ-011 Port FIFO_COUNT, output, AW+1 bits: records currently stored.
REQ-012 Ports FIFO_FULL and FIFO_EMPTY, output, 1 bit each: occupancy flags.
REQ-013 Port NTRIGGERS, output, 32 bits: accepted trigger count.
REQ-014 Port OVERFLOWS, output, 16 bits: triggers dropped because the FIFO was full.
REQ-015 Port STATE, output, 3 bits: current FSM state code.
REQ-016 Port ACQ_STOPPED, output, 1 bit: acquisition halted by STOP_ON_FULL.

Function
REQ-017 A free-running TS_W-bit timestamp counter SHALL increment every cycle, wrap modulo 2^TS_W, and clear on RESET or CLEAR.
REQ-018 A trigger edge SHALL be defined as TRIGGER_ACTIVE sampled 1 in the current cycle and 0 in the previous cycle.
REQ-019 FSM states SHALL be encoded IDLE=0, ARMED=1, CAPTURE=2, WRITE=3, HOLD=4, STOPPED=5.
REQ-020 IDLE→ARMED SHALL occur when ENABLE=1; any state other than IDLE SHALL go to IDLE within 1 cycle of ENABLE=0.
REQ-021 ARMED→CAPTURE SHALL occur on a trigger edge, and on the same edge the controller SHALL:
- latch the timestamp value present in that cycle;
- load the settle counter with SETTLE.
REQ-022 CAPTURE SHALL decrement the settle counter each cycle and go to WRITE when it reads 0, so that WRITE is entered SETTLE+1 cycles after the edge cycle.
REQ-023 WRITE SHALL last 1 cycle and SHALL:
- sample TOT_SHORT and TOT_LONG in that cycle;
- if not full, write the record at wr_ptr, advance wr_ptr modulo DEPTH, and increment NTRIGGERS;
- if full, write nothing and increment OVERFLOWS, saturating at 0xFFFF.
REQ-024 From WRITE, the next state SHALL be STOPPED if the FIFO is full after the write and STOP_ON_FULL=1; otherwise it SHALL be HOLD.
REQ-025 HOLD SHALL stay until TRIGGER_ACTIVE=0, then go to ARMED; a retrigger SHALL therefore require a fresh edge.
REQ-026 STOPPED SHALL assert ACQ_STOPPED, ignore triggers, and go to ARMED only when CLEAR=1, or when FIFO_EMPTY=1 and STOP_ON_FULL=0.
REQ-027 Trigger edges seen in CAPTURE, WRITE, HOLD, STOPPED or IDLE SHALL be ignored and SHALL NOT be counted.
REQ-028 NTRIGGERS SHALL wrap at 2^32.
REQ-029 Read: RD_REQ=1 with FIFO non-empty SHALL present rd_ptr's record on RD_DATA with RD_VALID=1 in the next cycle (1-cycle latency) and advance rd_ptr modulo DEPTH.
REQ-030 RD_REQ=1 with FIFO empty SHALL be ignored: RD_VALID=0, no pointer change.
REQ-031 RD_VALID SHALL be a single-cycle pulse per accepted pop.
REQ-032 RD_DATA SHALL hold its last value when RD_VALID=0.
REQ-033 A write and a read in the same cycle SHALL both take effect and leave FIFO_COUNT unchanged.
REQ-034 A write in the same cycle as a read SHALL be accepted even if FIFO_COUNT=DEPTH at the start of that cycle, because the pop frees a slot.
REQ-035 FIFO_FULL SHALL equal (FIFO_COUNT==DEPTH) and FIFO_EMPTY SHALL equal (FIFO_COUNT==0), both registered alongside the count.
REQ-036 CLEAR=1 SHALL, in the next cycle:
- zero the pointers, FIFO_COUNT, NTRIGGERS, OVERFLOWS and the timestamp;
- abort any CAPTURE/WRITE without writing;
- put the FSM in ARMED if ENABLE=1, else IDLE;
- not assert RD_VALID.
REQ-037 CLEAR SHALL take priority over a simultaneous write or read.

Reset
REQ-038 While RESET=0 at a rising edge of CLK, the block SHALL set:
- STATE=IDLE;
- RD_VALID=0, RD_DATA=0;
- FIFO_COUNT=0, FIFO_EMPTY=1, FIFO_FULL=0;
- NTRIGGERS=0, OVERFLOWS=0, ACQ_STOPPED=0;
- pointers, timestamp and settle counter cleared.
REQ-039 Reset asserted mid-capture SHALL discard the pending record.
REQ-040 Stored memory contents need not clear on reset.
REQ-041 Outputs SHALL be valid on the first edge after RESET returns to 1.

Verification
REQ-042 ENABLE=1, SETTLE=3, trigger edge at timestamp 100, TOT_SHORT=0x0012 and TOT_LONG=0x0345 stable -> WRITE at edge+4 cycles; FIFO_COUNT=1; NTRIGGERS=1; a pop returns {100, 0x0012, 0x0345} one cycle after RD_REQ.
REQ-043 DEPTH=256 with STOP_ON_FULL=0, 260 separated triggers -> FIFO_COUNT=256, FIFO_FULL=1, OVERFLOWS=4, NTRIGGERS=256; then 256 pops return records in order and FIFO_EMPTY=1.
REQ-044 FIFO full with STOP_ON_FULL=1 -> STATE=STOPPED, ACQ_STOPPED=1; further triggers change neither counter; CLEAR=1 -> all counters 0, STATE=ARMED.
REQ-045 FIFO_COUNT=256, RD_REQ coincident with WRITE -> record accepted, FIFO_COUNT stays 256, OVERFLOWS unchanged.
REQ-046 TRIGGER_ACTIVE held high 50 cycles, plus a second edge during CAPTURE -> exactly 1 record, NTRIGGERS=1.
REQ-047 RESET=0 during CAPTURE -> no record written, all outputs at reset values the next cycle; ENABLE=0 during CAPTURE -> IDLE within 1 cycle, FIFO_COUNT unchanged.
